// File: rtl/vote_collector.sv
// Purpose: serial plurality vote; tallies 2**M ballots, then scans 2**N tallies for the winner.
// Latency: done rises 2**N cycles after the edge that accepts the last ballot.
// Backpressure: vote_ready is high only while collecting; offered ballots are dropped otherwise.
module vote_collector #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         vote_valid,
  input  logic [N-1:0] vote,
  output logic         vote_ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
  output logic [M:0]   winner_count
);

  localparam int NC = 1 << N;
  localparam int NV = 1 << M;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [M:0]   tally_q [NC];
  logic [M:0]   tally_d [NC];
  logic [M:0]   cnt_q, cnt_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] best_q, best_d;
  logic [M:0]   best_cnt_q, best_cnt_d;
  logic [N-1:0] winner_q, winner_d;
  logic [M:0]   winner_count_q, winner_count_d;

  logic accept, last_ballot, last_cand, scan_take, start_new;

  assign accept      = (state_q == S_COLLECT) && vote_valid;
  assign last_ballot = accept && (cnt_q == (M+1)'(NV - 1));
  assign last_cand   = (idx_q == N'(NC - 1));
  assign scan_take   = tally_q[idx_q] > best_cnt_q;
  assign start_new   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start is ignored while an election is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)       state_d = S_COLLECT;
      S_COLLECT: if (last_ballot) state_d = S_SCAN;
      S_SCAN:    if (last_cand)   state_d = S_DONE;
      S_DONE:    if (start)       state_d = S_COLLECT;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only, so no input reaches an output combinationally
  always_comb begin
    vote_ready   = (state_q == S_COLLECT);
    busy         = (state_q == S_COLLECT) || (state_q == S_SCAN);
    done         = (state_q == S_DONE);
    winner       = winner_q;
    winner_count = winner_count_q;
  end

  // Datapath next-state: clear on a new election, tally accepted ballots, strict-greater scan
  always_comb begin
    for (int i = 0; i < NC; i++) tally_d[i] = tally_q[i];
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    best_d         = best_q;
    best_cnt_d     = best_cnt_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;

    if (start_new) begin
      for (int i = 0; i < NC; i++) tally_d[i] = '0;
      cnt_d          = '0;
      winner_d       = '0;
      winner_count_d = '0;
    end else if (accept) begin
      tally_d[vote] = tally_q[vote] + (M+1)'(1);
      cnt_d         = cnt_q + (M+1)'(1);
      if (last_ballot) begin
        // Running best starts at candidate 0 with an empty count
        idx_d      = '0;
        best_d     = '0;
        best_cnt_d = '0;
      end
    end else if (state_q == S_SCAN) begin
      // Strict compare keeps the lower index on a tie
      if (scan_take) begin
        best_d     = idx_q;
        best_cnt_d = tally_q[idx_q];
      end
      idx_d = idx_q + N'(1);
      if (last_cand) begin
        winner_d       = scan_take ? idx_q : best_q;
        winner_count_d = scan_take ? tally_q[idx_q] : best_cnt_q;
      end
    end
  end

  // Datapath registers; reset discards any partial election
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) tally_q[i] <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
      best_q         <= '0;
      best_cnt_q     <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
    end else begin
      for (int i = 0; i < NC; i++) tally_q[i] <= tally_d[i];
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      best_q         <= best_d;
      best_cnt_q     <= best_cnt_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
    end
  end

endmodule

// File: tb/tb_vote_collector.sv
module tb_vote_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, vote_valid;
  logic [1:0] vote;
  logic       vote_ready, busy, done;
  logic [1:0] winner;
  logic [2:0] winner_count;

  logic       start_b, vv_b;
  logic [2:0] vote_b;
  logic       rdy_b, busy_b, done_b;
  logic [2:0] win_b;
  logic [4:0] wc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vote_collector #(.N(2), .M(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote(vote),
    .vote_ready(vote_ready), .busy(busy), .done(done), .winner(winner),
    .winner_count(winner_count)
  );

  vote_collector #(.N(3), .M(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vote_valid(vv_b), .vote(vote_b),
    .vote_ready(rdy_b), .busy(busy_b), .done(done_b), .winner(win_b),
    .winner_count(wc_b)
  );

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers four ballots (bl[1:0] first) with optional random idle gaps, then
  // optionally keeps offering a fifth ballot; returns vote_ready right after the
  // fourth accept and the number of cycles until done (-1 on timeout).
  task automatic feed_ballots(input logic [7:0] bl, input int gap_max, input bit fifth,
                              input logic [1:0] fifth_v, output logic rdy_after,
                              output int lat);
    int gaps;
    for (int i = 0; i < 4; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) begin
        vote_valid = 1'b0;
        @(negedge clk);
      end
      vote_valid = 1'b1;
      vote       = bl[2*i +: 2];
      @(negedge clk);
    end
    rdy_after  = vote_ready;
    vote_valid = fifth;
    vote       = fifth_v;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    vote_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; vote_valid = 1'b0; vote = '0;
    start_b = 1'b0; vv_b = 1'b0; vote_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({vote_ready, busy, done} !== 3'b000 || winner !== 2'd0 || winner_count !== 3'd0) begin
      errors++;
      $display("FAIL reset: ready/busy/done=%b%b%b winner=%0d count=%0d, want 000 0 0",
               vote_ready, busy, done, winner, winner_count);
    end
  endtask

  task automatic test_basic();
    logic rdy; int lat;
    start_pulse();
    checks++;
    if (vote_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_collect: ready=%b busy=%b, want 1 1", vote_ready, busy);
    end
    feed_ballots({2'd3, 2'd2, 2'd1, 2'd1}, 0, 1'b0, 2'd0, rdy, lat);
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL basic_ready_drop: ready=%b, want 0", rdy);
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL basic_latency: got %0d cycles, want 4", lat);
    end
    checks++;
    if (winner !== 2'd1 || winner_count !== 3'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: winner=%0d count=%0d busy=%b, want 1 2 0",
               winner, winner_count, busy);
    end
  endtask

  task automatic test_tie();
    logic rdy; int lat;
    start_pulse();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL tie_done_clear: done=%b, want 0", done);
    end
    feed_ballots({2'd2, 2'd3, 2'd3, 2'd2}, 0, 1'b0, 2'd0, rdy, lat);
    checks++;
    if (lat !== 4 || winner !== 2'd2 || winner_count !== 3'd2) begin
      errors++;
      $display("FAIL tie_result: lat=%0d winner=%0d count=%0d, want 4 2 2",
               lat, winner, winner_count);
    end
  endtask

  task automatic test_unanimous();
    logic rdy; int lat;
    start_pulse();
    feed_ballots({2'd3, 2'd3, 2'd3, 2'd3}, 0, 1'b0, 2'd0, rdy, lat);
    checks++;
    if (lat !== 4 || winner !== 2'd3 || winner_count !== 3'd4) begin
      errors++;
      $display("FAIL unanimous_result: lat=%0d winner=%0d count=%0d, want 4 3 4",
               lat, winner, winner_count);
    end
  endtask

  task automatic test_gaps_fifth();
    logic rdy; int lat;
    start_pulse();
    // 1,0,1,0 ties on 0; an accepted fifth ballot for 1 would flip the result
    feed_ballots({2'd0, 2'd1, 2'd0, 2'd1}, 3, 1'b1, 2'd1, rdy, lat);
    checks++;
    if (lat !== 4 || winner !== 2'd0 || winner_count !== 3'd2) begin
      errors++;
      $display("FAIL gaps_fifth_result: lat=%0d winner=%0d count=%0d, want 4 0 2",
               lat, winner, winner_count);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy; int lat;
    start_pulse();
    vote_valid = 1'b1; vote = 2'd0;
    repeat (2) @(negedge clk);
    vote_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || vote_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: busy=%b ready=%b, want 0 0", busy, vote_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || winner !== 2'd0 || winner_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: done=%b winner=%0d count=%0d, want 0 0 0",
               done, winner, winner_count);
    end
    start_pulse();
    feed_ballots({2'd1, 2'd0, 2'd0, 2'd0}, 0, 1'b0, 2'd0, rdy, lat);
    checks++;
    if (lat !== 4 || winner !== 2'd0 || winner_count !== 3'd3) begin
      errors++;
      $display("FAIL reset_mid_result: lat=%0d winner=%0d count=%0d, want 4 0 3",
               lat, winner, winner_count);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] bl;
    logic rdy; int lat;
    start_pulse();
    bl = {2'd3, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) begin
      vote_valid = 1'b1; vote = bl[2*i +: 2];
      @(negedge clk);
      if (i == 1) begin
        vote_valid = 1'b0;
        start_pulse();   // during COLLECT
      end
    end
    vote_valid = 1'b0;
    start_pulse();       // during SCAN
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 4 || winner !== 2'd1 || winner_count !== 3'd2) begin
      errors++;
      $display("FAIL start_ignored_result: lat=%0d winner=%0d count=%0d, want 4 1 2",
               lat, winner, winner_count);
    end
    start_pulse();       // in DONE: restart
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || winner !== 2'd0 || winner_count !== 3'd0) begin
      errors++;
      $display("FAIL start_done_clear: done=%b busy=%b winner=%0d count=%0d, want 0 1 0 0",
               done, busy, winner, winner_count);
    end
    feed_ballots({2'd0, 2'd2, 2'd2, 2'd3}, 0, 1'b0, 2'd0, rdy, lat);
    checks++;
    if (lat !== 4 || winner !== 2'd2 || winner_count !== 3'd2) begin
      errors++;
      $display("FAIL second_election: lat=%0d winner=%0d count=%0d, want 4 2 2",
               lat, winner, winner_count);
    end
  endtask

  task automatic test_random_wide();
    int tl [8];
    int sent, bw, bc, lat;
    logic [2:0] b;
    for (int e = 0; e < 1000; e++) begin
      for (int i = 0; i < 8; i++) tl[i] = 0;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      sent = 0;
      while (sent < 16) begin
        if ($urandom_range(0, 3) != 0) begin
          b = 3'($urandom_range(0, 7));
          vv_b = 1'b1; vote_b = b;
          tl[b]++;
          sent++;
        end else begin
          vv_b = 1'b0;
        end
        @(negedge clk);
      end
      vv_b = 1'b0;
      bw = 0; bc = tl[0];
      for (int i = 1; i < 8; i++) if (tl[i] > bc) begin bw = i; bc = tl[i]; end
      lat = -1;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (done_b) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat !== 8 || win_b !== 3'(bw) || wc_b !== 5'(bc)) begin
        errors++;
        $display("FAIL random_%0d: lat=%0d winner=%0d count=%0d, want 8 %0d %0d",
                 e, lat, win_b, wc_b, bw, bc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_unanimous();
    test_gaps_fifth();
    test_reset_mid();
    test_start_ignored();
    test_random_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
